// File: rtl/mips_mc_pkg.sv
// Shared multicycle MIPS definitions: next-PC select encodings, IR field positions, opcodes.
package mips_mc_pkg;

  typedef enum logic [1:0] {
    PCSRC_ALURES = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pcsrc_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int IMM_MSB    = 15;
  localparam int FUNCT_MSB  = 5;
  localparam int JADDR_MSB  = 25;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

endpackage

// File: rtl/flopenr.sv
// Enable register with synchronous reset to a fixed value; q follows d one cycle after an enabled edge.
module flopenr #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Multicycle MIPS fetch stage: PC/IR/MDR registers, IR field slicing, memory address mux; 1-cycle register
// latency, stalls the controller while mem_ready is low. Optional counters under MIPS_PERF_CNT_EN.
module mips_fetch_unit
  import mips_mc_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PCWrite,
  input  logic             Branch,
  input  logic             Zero,
  input  logic             IorD,
  input  logic             IRWrite,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_req,
  output logic             stall,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] Instr,
  output logic [WIDTH-1:0] Data,
  output logic [5:0]       Opcode,
  output logic [5:0]       Funct,
  output logic [4:0]       Rs,
  output logic [4:0]       Rt,
  output logic [4:0]       Rd,
  output logic [15:0]      Imm
`ifdef MIPS_PERF_CNT_EN
  ,
  output logic [31:0]      cycle_count,
  output logic [31:0]      instr_count
`endif
);

  logic             pc_en;
  logic             ir_en;
  logic             mdr_en;
  logic [WIDTH-1:0] pc_next;

  assign mem_addr = IorD ? ALUOut : PC;
  assign mem_req  = IRWrite | IorD;
  assign stall    = mem_req & ~mem_ready;

  // PCSRC_HOLD makes the enable irrelevant, so it is masked here rather than muxed.
  assign pc_en  = (PCWrite | (Branch & Zero)) & ~stall & (pcsrc_t'(PCSrc) != PCSRC_HOLD);
  assign ir_en  = IRWrite & mem_ready;
  assign mdr_en = mem_ready;

  always_comb begin
    pc_next = PC;
    case (pcsrc_t'(PCSrc))
      PCSRC_ALURES: pc_next = ALUResult;
      PCSRC_ALUOUT: pc_next = ALUOut;
      // PC has already been incremented in fetch, so its top nibble is that of PC+4.
      PCSRC_JUMP:   pc_next = {PC[WIDTH-1 -: 4], Instr[JADDR_MSB:0], 2'b00};
      PCSRC_HOLD:   pc_next = PC;
      default:      pc_next = PC;
    endcase
  end

  flopenr #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk(Clk), .reset(Reset), .en(pc_en), .d(pc_next), .q(PC)
  );

  flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_ir_reg (
    .clk(Clk), .reset(Reset), .en(ir_en), .d(mem_rdata), .q(Instr)
  );

  flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_mdr_reg (
    .clk(Clk), .reset(Reset), .en(mdr_en), .d(mem_rdata), .q(Data)
  );

  assign Opcode = Instr[OPCODE_MSB:OPCODE_LSB];
  assign Rs     = Instr[RS_MSB:RS_LSB];
  assign Rt     = Instr[RT_MSB:RT_LSB];
  assign Rd     = Instr[RD_MSB:RD_LSB];
  assign Imm    = Instr[IMM_MSB:0];
  assign Funct  = Instr[FUNCT_MSB:0];

`ifdef MIPS_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (ir_en) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: fetch, wait states, branch, jump, load, reset mid-stall.
module tb_mips_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset, PCWrite, Branch, Zero, IorD, IRWrite, mem_ready;
  logic [1:0]  PCSrc;
  logic [31:0] ALUResult, ALUOut, mem_rdata;
  logic [31:0] mem_addr, PC, Instr, Data;
  logic        mem_req, stall;
  logic [5:0]  Opcode, Funct;
  logic [4:0]  Rs, Rt, Rd;
  logic [15:0] Imm;
`ifdef MIPS_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mips_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .Branch(Branch), .Zero(Zero),
    .IorD(IorD), .IRWrite(IRWrite), .PCSrc(PCSrc), .ALUResult(ALUResult),
    .ALUOut(ALUOut), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_req(mem_req), .stall(stall), .PC(PC),
    .Instr(Instr), .Data(Data), .Opcode(Opcode), .Funct(Funct),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm(Imm)
`ifdef MIPS_PERF_CNT_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; PCWrite = 1'b0; Branch = 1'b0; Zero = 1'b0; IorD = 1'b0;
    IRWrite = 1'b0; mem_ready = 1'b0; PCSrc = 2'b00;
    ALUResult = '0; ALUOut = '0; mem_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_pc", PC, 32'h0);
    chk("rst_ir", Instr, 32'h0);
    chk("rst_mdr", Data, 32'h0);
    chk("rst_opcode", {26'd0, Opcode}, 32'h0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'h0);
`ifdef MIPS_PERF_CNT_EN
    chk("rst_cycles", cycle_count, 32'h0);
    chk("rst_instrs", instr_count, 32'h0);
`endif

    // Zero-wait fetch of lw $3,4($2)
    Reset = 1'b0; IRWrite = 1'b1; PCWrite = 1'b1; PCSrc = 2'b00;
    ALUResult = 32'h4; mem_rdata = 32'h8C43_0004; mem_ready = 1'b1;
    #1;
    chk("f0_addr", mem_addr, 32'h0);
    chk("f0_req", {31'd0, mem_req}, 32'h1);
    chk("f0_stall", {31'd0, stall}, 32'h0);
    tick();
    chk("f0_pc", PC, 32'h4);
    chk("f0_ir", Instr, 32'h8C43_0004);
    chk("f0_opcode", {26'd0, Opcode}, 32'h23);
    chk("f0_rs", {27'd0, Rs}, 32'h2);
    chk("f0_rt", {27'd0, Rt}, 32'h3);
    chk("f0_rd", {27'd0, Rd}, 32'h0);
    chk("f0_imm", {16'd0, Imm}, 32'h4);
    chk("f0_funct", {26'd0, Funct}, 32'h4);
    chk("f0_mdr", Data, 32'h8C43_0004);
`ifdef MIPS_PERF_CNT_EN
    chk("f0_cycles", cycle_count, 32'h1);
    chk("f0_instrs", instr_count, 32'h1);
`endif

    // Fetch of j 0x40 with two wait cycles
    ALUResult = 32'h8; mem_rdata = 32'h0800_0010; mem_ready = 1'b0;
    #1;
    chk("w0_stall", {31'd0, stall}, 32'h1);
    chk("w0_addr", mem_addr, 32'h4);
    tick();
    chk("w1_pc", PC, 32'h4);
    chk("w1_ir", Instr, 32'h8C43_0004);
    chk("w1_stall", {31'd0, stall}, 32'h1);
    tick();
    chk("w2_pc", PC, 32'h4);
    chk("w2_ir", Instr, 32'h8C43_0004);
    mem_ready = 1'b1;
    #1;
    chk("w2_stall", {31'd0, stall}, 32'h0);
    tick();
    chk("w3_pc", PC, 32'h8);
    chk("w3_ir", Instr, 32'h0800_0010);
    chk("w3_opcode", {26'd0, Opcode}, 32'h02);
    chk("w3_mdr", Data, 32'h0800_0010);

    // Move PC into the 0x1xxx_xxxx region, then jump
    IRWrite = 1'b0; mem_ready = 1'b0; PCWrite = 1'b1; PCSrc = 2'b00;
    ALUResult = 32'h1000_0008;
    #1;
    chk("j_req", {31'd0, mem_req}, 32'h0);
    tick();
    chk("j_setup_pc", PC, 32'h1000_0008);
    PCSrc = 2'b10;
    tick();
    chk("j_pc", PC, 32'h1000_0040);
    chk("j_mdr_hold", Data, 32'h0800_0010);

    // PCSrc=11 holds even with PCWrite
    PCSrc = 2'b11;
    tick();
    chk("hold_pc", PC, 32'h1000_0040);

    // BEQ not taken, then taken
    PCWrite = 1'b0; Branch = 1'b1; PCSrc = 2'b01; ALUOut = 32'h40; Zero = 1'b0;
    tick();
    chk("beq_nt_pc", PC, 32'h1000_0040);
    Zero = 1'b1;
    tick();
    chk("beq_t_pc", PC, 32'h40);
    Branch = 1'b0; Zero = 1'b0;

    // Load data phase with one wait cycle
    IorD = 1'b1; ALUOut = 32'h100; mem_rdata = 32'hDEAD_BEEF; mem_ready = 1'b0;
    #1;
    chk("ld_addr", mem_addr, 32'h100);
    chk("ld_stall", {31'd0, stall}, 32'h1);
    tick();
    chk("ld_mdr_wait", Data, 32'h0800_0010);
    mem_ready = 1'b1;
    tick();
    chk("ld_mdr", Data, 32'hDEAD_BEEF);
    chk("ld_ir", Instr, 32'h0800_0010);
    chk("ld_pc", PC, 32'h40);

    // Reset during a stalled fetch
    IorD = 1'b0; IRWrite = 1'b1; PCWrite = 1'b1; PCSrc = 2'b00;
    ALUResult = 32'h44; mem_ready = 1'b0;
    #1;
    chk("rs_stall", {31'd0, stall}, 32'h1);
    Reset = 1'b1;
    tick();
    chk("rs_pc", PC, 32'h0);
    chk("rs_ir", Instr, 32'h0);
    chk("rs_mdr", Data, 32'h0);
    chk("rs_req", {31'd0, mem_req}, 32'h1);
`ifdef MIPS_PERF_CNT_EN
    chk("rs_cycles", cycle_count, 32'h0);
    chk("rs_instrs", instr_count, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Upstream fetch/decode-feed stage of the multicycle MIPS core. It owns the program counter, the instruction register (IR) and the memory data register (MDR), and gates PC updates from controller strobes and the ALU Zero flag. It slices the IR into the fields consumed by the main decoder, the ALU decoder and the register file. It also drives the unified memory address and stalls the controller while memory is not ready.

## Interface
- `WIDTH`, 32: datapath width; must be 32, since the jump-target field slicing assumes it.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `Clk`  in  1  system clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `PCWrite`  in  1  unconditional PC write strobe from controller.
- `Branch`  in  1  conditional PC write strobe from controller.
- `Zero`  in  1  ALU zero flag.
- `IorD`  in  1  address select: 0 = PC, 1 = ALUOut.
- `IRWrite`  in  1  instruction register load request.
- `PCSrc`  in  2  next-PC select.
- `ALUResult`  in  WIDTH  combinational ALU output (PC+4 in fetch state).
- `ALUOut`  in  WIDTH  registered ALU output (branch target / data address).
- `mem_rdata`  in  WIDTH  memory read data.
- `mem_ready`  in  1  memory read data valid / write accepted this cycle.
- `mem_addr`  out  WIDTH  memory address.
- `mem_req`  out  1  memory access pending.
- `stall`  out  1  controller must hold its state this cycle.
- `PC`  out  WIDTH  current PC.
- `Instr`  out  WIDTH  IR contents.
- `Data`  out  WIDTH  MDR contents.
- `Opcode`  out  6  Instr[31:26].
- `Funct`  out  6  Instr[5:0].
- `Rs`, `Rt`, `Rd`  out  5 each  Instr[25:21], [20:16], [15:11].
- `Imm`  out  16  Instr[15:0].
- `cycle_count`, `instr_count`  out  32 each  present only with `MIPS_PERF_CNT_EN`.

## Operation
- `mem_addr = IorD ? ALUOut : PC`.
- `mem_req = IRWrite | IorD`.
- `stall = mem_req & ~mem_ready`.
- Stall semantics: while `stall` is high, PC, IR and MDR hold. The controller is required to keep its strobes stable until `stall` drops.
- `PCEn = (PCWrite | (Branch & Zero)) & ~stall`.
- Next PC by `PCSrc`:
  - 00: ALUResult.
  - 01: ALUOut.
  - 10: {PC[31:28], Instr[25:0], 2'b00}, using the already-incremented PC.
  - 11: PC, i.e. hold; PCEn is ignored.
- IR loads `mem_rdata` when `IRWrite & mem_ready`.
- MDR loads `mem_rdata` on every cycle with `mem_ready` high. It holds otherwise.
- Field outputs are pure slices of IR, so they follow IR with no extra latency.
- Reset values:
  - PC = RESET_PC.
  - IR = 0, so Opcode = 0 and the R-type decode path is taken harmlessly.
  - MDR = 0.
  - Counters = 0.
- Reset has priority over every strobe in the same cycle.
- Reset mid-stall aborts the access. After reset, `mem_req` is driven combinationally from the strobes only.

## Timing
- All registers update on the rising `Clk` edge.
- PC, IR and MDR show new values one cycle after the enabling edge.
- `mem_addr`, `mem_req`, `stall` and next-PC are combinational, with zero latency.
- With zero-wait memory (`mem_ready` tied high), the fetch state takes exactly 1 cycle: IR and PC+4 are both written on the same edge.
- With N wait cycles, the fetch state takes N+1 cycles and `stall` is high for N cycles.
- When PCWrite and Branch are both asserted, PCWrite dominates; the resulting PCEn is the same.
- When `Branch=1` and `Zero=0`, the PC holds.

## Configuration
- `MIPS_PERF_CNT_EN` defined:
  - `cycle_count` increments every non-reset cycle.
  - `instr_count` increments on each IR load.
  - Both counters wrap modulo 2^32.
- `MIPS_PERF_CNT_EN` undefined: counter ports and logic are absent.

## Structure
- Shared package `mips_mc_pkg` holds:
  - PCSrc encodings: PCSRC_ALURES, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_HOLD.
  - Instruction field bit-position constants.
  - Opcode constants shared with the main decoder.
- One natural sub-module, `flopenr`: a WIDTH-parameterised enable register with synchronous reset value. It is instantiated for PC, IR and MDR.

## Test plan
- Reset, then zero-wait fetch with `IRWrite=PCWrite=1`, `PCSrc=00`, `ALUResult=4`, `mem_rdata=32'h8C43_0004`:
  - Next edge gives PC=4, Instr=32'h8C43_0004, Opcode=6'b100011, Rs=2, Rt=3, Imm=4.
- Two wait cycles (`mem_ready=0`, 0, 1) during fetch:
  - `stall` is 1,1,0.
  - PC and IR change only on the third edge.
- BEQ resolution, `Branch=1`, `PCSrc=01`, `ALUOut=32'h40`:
  - `Zero=1` gives PC=32'h40.
  - `Zero=0` leaves PC unchanged.
- Jump with PC=32'h1000_0008, Instr[25:0]=26'h000_0010, `PCWrite=1`, `PCSrc=10`:
  - PC=32'h1000_0040.
- Load data phase, `IorD=1`, `ALUOut=32'h100`:
  - `mem_addr=32'h100`.
  - MDR captures `mem_rdata` on the `mem_ready` edge.
  - IR is unchanged.
- `Reset` asserted during a stalled fetch:
  - PC=RESET_PC and IR=0 on the next edge.
  - With `MIPS_PERF_CNT_EN` defined, both counters read 0.
